// File: rtl/lap_record_queue_if.sv
// Handshake bundle between the key FSM, the lap record queue and the LCD bridge.
// The master side drives lap/clear requests and the bridge busy flag.
interface lap_record_queue_if #(
  parameter int REC_W = 32,
  parameter int AW    = 3
);
  logic             lap_req;
  logic [REC_W-1:0] record_in;
  logic             clear_req;
  logic             lcd_busy;
  logic             lcd_insert;
  logic [REC_W-1:0] lcd_record;
  logic             lcd_clear;
  logic [AW:0]      count;
  logic             full;
  logic             overflow;
  logic             q_busy;

  modport master (
    output lap_req, record_in, clear_req, lcd_busy,
    input  lcd_insert, lcd_record, lcd_clear, count, full, overflow, q_busy
  );

  modport slave (
    input  lap_req, record_in, clear_req, lcd_busy,
    output lcd_insert, lcd_record, lcd_clear, count, full, overflow, q_busy
  );
endinterface

// File: rtl/lap_record_queue.sv
// FIFO of lap timestamps replayed to the LCD bridge over its insert/busy handshake,
// with clear requests serialised behind any record already in flight.
module lap_record_queue #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int REC_W       = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  lap_record_queue_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_RISE, WAIT_FALL, CLR_ISSUE, CLR_WAIT_RISE, CLR_WAIT_FALL
  } state_t;

  localparam int              TW        = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
  // The issue cycle itself counts as the first waited cycle.
  localparam logic [TW-1:0]   TMO_LAST  = TW'(ACK_TIMEOUT - 2);

  logic [REC_W-1:0] mem [DEPTH];

  state_t           state_reg, state_next;
  logic [TW-1:0]    tmo_reg, tmo_next;
  logic             clear_pending_reg, clear_pending_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             overflow_reg;
  logic             lcd_insert_reg, lcd_clear_reg;
  logic [REC_W-1:0] lcd_record_reg;

  logic full, pop, push, drop, clear_take;

  assign full = (count_reg == FULL_CNT);

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    pop        = 1'b0;
    clear_take = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear_pending_reg) begin
          clear_take = 1'b1;
          state_next = CLR_ISSUE;
        end else if (count_reg != '0 && !bus.lcd_busy && !bus.clear_req) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        tmo_next   = '0;
        state_next = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (bus.lcd_busy)             state_next = WAIT_FALL;
        else if (tmo_reg == TMO_LAST) state_next = IDLE;
        else                          tmo_next   = tmo_reg + 1'b1;
      end
      WAIT_FALL: begin
        if (!bus.lcd_busy) state_next = IDLE;
      end
      CLR_ISSUE: begin
        tmo_next   = '0;
        state_next = CLR_WAIT_RISE;
      end
      CLR_WAIT_RISE: begin
        if (bus.lcd_busy)             state_next = CLR_WAIT_FALL;
        else if (tmo_reg == TMO_LAST) state_next = IDLE;
        else                          tmo_next   = tmo_reg + 1'b1;
      end
      CLR_WAIT_FALL: begin
        if (!bus.lcd_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A clear arriving while another is pending or being taken merges into it.
    clear_pending_next = (clear_pending_reg & ~clear_take) | (bus.clear_req & ~clear_pending_reg);

    // A pop in the same cycle frees a slot, so a lap is accepted even when full.
    push = bus.lap_req & ~bus.clear_req & (~full | pop);
    drop = bus.lap_req & ~bus.clear_req & full & ~pop;
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= bus.record_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      tmo_reg           <= '0;
      clear_pending_reg <= 1'b0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      overflow_reg      <= 1'b0;
      lcd_insert_reg    <= 1'b0;
      lcd_clear_reg     <= 1'b0;
      lcd_record_reg    <= '0;
    end else begin
      state_reg         <= state_next;
      tmo_reg           <= tmo_next;
      clear_pending_reg <= clear_pending_next;
      lcd_insert_reg    <= (state_next == ISSUE);
      lcd_clear_reg     <= (state_next == CLR_ISSUE);
      if (pop) lcd_record_reg <= mem[rd_ptr_reg];

      if (bus.clear_req) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !push) count_reg <= count_reg - 1'b1;
        if (drop) overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.lcd_insert = lcd_insert_reg;
  assign bus.lcd_clear  = lcd_clear_reg;
  assign bus.lcd_record = lcd_record_reg;
  assign bus.count      = count_reg;
  assign bus.full       = full;
  assign bus.overflow   = overflow_reg;
  assign bus.q_busy     = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_lap_record_queue.sv
// Scenario bench for lap_record_queue: a scoreboard of queued records is checked
// against every insert, with a behavioural LCD bridge that can hold, answer or ignore.
module tb_lap_record_queue;

  localparam int DEPTH       = 8;
  localparam int AW          = 3;
  localparam int REC_W       = 32;
  localparam int ACK_TIMEOUT = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  lap_record_queue_if #(.REC_W(REC_W), .AW(AW)) bus ();

  lap_record_queue #(
    .DEPTH(DEPTH), .AW(AW), .REC_W(REC_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          ins_cyc[$];
  int          insert_cnt = 0;
  int          clear_cnt  = 0;
  int          bridge_mode = 0;   // 0 answers strobes, 1 holds busy, 2 never busy
  int          busy_cnt   = 0;
  bit          hs_chk     = 1'b0;
  bit          saw_busy   = 1'b0;
  bit          prev_strobe = 1'b0;

  // Bridge model: raises busy for three cycles one cycle after each strobe.
  initial begin
    bus.lcd_busy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (bridge_mode)
        1: begin bus.lcd_busy = 1'b1; busy_cnt = 0; end
        2: begin bus.lcd_busy = 1'b0; busy_cnt = 0; end
        default: begin
          if (busy_cnt > 0) begin
            bus.lcd_busy = 1'b1;
            busy_cnt--;
          end else begin
            bus.lcd_busy = 1'b0;
          end
          if (bus.lcd_insert || bus.lcd_clear) busy_cnt = 3;
        end
      endcase
    end
  end

  // Output monitor: pops the scoreboard on each insert.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (bus.lcd_insert) begin
        insert_cnt++;
        ins_cyc.push_back(cyc);
        $display("cycle %0d insert record=%h", cyc, bus.lcd_record);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL insert_unexpected: got record %h, none queued", bus.lcd_record);
        end else begin
          e = exp_q.pop_front();
          if (bus.lcd_record !== e) begin
            bad++;
            $display("FAIL insert_record: got %h expected %h", bus.lcd_record, e);
          end
        end
        if (hs_chk) begin
          total++;
          if (!saw_busy) begin
            bad++;
            $display("FAIL insert_handshake: got insert with no busy since last, expected full handshake");
          end
        end
        saw_busy = 1'b0;
      end
      if (bus.lcd_clear) begin
        clear_cnt++;
        $display("cycle %0d lcd clear", cyc);
      end
      if (bus.lcd_insert || bus.lcd_clear) begin
        total++;
        if ((bus.lcd_insert && bus.lcd_clear) || prev_strobe) begin
          bad++;
          $display("FAIL strobe_spacing: got insert=%b clear=%b prev=%b, expected one isolated strobe",
                   bus.lcd_insert, bus.lcd_clear, prev_strobe);
        end
      end
      prev_strobe = bus.lcd_insert || bus.lcd_clear;
      if (bus.lcd_busy) saw_busy = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller must be at a falling edge; leaves at the next falling edge.
  task automatic lap(input logic [31:0] rec, input bit accept);
    bus.lap_req   = 1'b1;
    bus.record_in = rec;
    if (accept) exp_q.push_back(rec);
    @(negedge clock);
    bus.lap_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    int stable;
    stable = 0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (!bus.q_busy && !bus.lcd_busy) stable++;
      else stable = 0;
      if (stable >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    total += 7;
    if (bus.lcd_insert !== 1'b0) begin bad++; $display("FAIL reset_insert: got %b expected 0", bus.lcd_insert); end
    if (bus.lcd_clear  !== 1'b0) begin bad++; $display("FAIL reset_clear: got %b expected 0", bus.lcd_clear); end
    if (bus.lcd_record !== 32'h0) begin bad++; $display("FAIL reset_record: got %h expected 0", bus.lcd_record); end
    if (bus.count      !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    if (bus.full       !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    if (bus.overflow   !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    if (bus.q_busy     !== 1'b0) begin bad++; $display("FAIL reset_q_busy: got %b expected 0", bus.q_busy); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic;
    bit ok;
    bridge_mode = 0;
    lap(32'h0012_3456, 1'b1);
    total += 2;
    if (bus.count !== 4'd1) begin bad++; $display("FAIL basic_count_stored: got %0d expected 1", bus.count); end
    if (bus.lcd_insert !== 1'b0) begin bad++; $display("FAIL basic_insert_early: got %b expected 0", bus.lcd_insert); end
    @(negedge clock);
    total += 3;
    if (bus.lcd_insert !== 1'b1) begin bad++; $display("FAIL basic_insert_latency: got %b expected 1", bus.lcd_insert); end
    if (bus.lcd_record !== 32'h0012_3456) begin bad++; $display("FAIL basic_record: got %h expected 00123456", bus.lcd_record); end
    if (bus.count !== 4'd0) begin bad++; $display("FAIL basic_count_popped: got %0d expected 0", bus.count); end
    wait_idle(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_idle_timeout: got busy, expected idle within 100 cycles"); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int ins0;
    bridge_mode = 1;
    repeat (2) @(negedge clock);
    for (int i = 1; i <= 5; i++) lap(32'(i), 1'b1);
    total += 2;
    if (bus.count !== 4'd5) begin bad++; $display("FAIL bp_count: got %0d expected 5", bus.count); end
    if (bus.full !== 1'b0) begin bad++; $display("FAIL bp_full: got %b expected 0", bus.full); end
    ins0 = insert_cnt;
    hs_chk = 1'b1;
    bridge_mode = 0;
    wait_idle(400, ok);
    hs_chk = 1'b0;
    total += 3;
    if (!ok) begin bad++; $display("FAIL bp_idle_timeout: got busy, expected idle within 400 cycles"); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d records left, expected 0", exp_q.size()); end
    if (insert_cnt - ins0 != 5) begin bad++; $display("FAIL bp_inserts: got %0d expected 5", insert_cnt - ins0); end
  endtask

  task automatic test_overflow;
    bit ok;
    int ins0;
    bridge_mode = 1;
    repeat (2) @(negedge clock);
    for (int i = 1; i <= 9; i++) lap(32'h100 + 32'(i), i <= DEPTH);
    total += 3;
    if (bus.count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d expected 8", bus.count); end
    if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b expected 1", bus.full); end
    if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
    ins0 = insert_cnt;
    bridge_mode = 0;
    wait_idle(600, ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL ovf_idle_timeout: got busy, expected idle within 600 cycles"); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_drain: got %0d records left, expected 0", exp_q.size()); end
    if (insert_cnt - ins0 != 8) begin bad++; $display("FAIL ovf_inserts: got %0d expected 8", insert_cnt - ins0); end
    if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
  endtask

  task automatic test_clear_inflight;
    bit ok;
    int ins0, clr0, n;
    bridge_mode = 1;
    repeat (2) @(negedge clock);
    for (int i = 1; i <= 3; i++) lap(32'h200 + 32'(i), 1'b1);
    ins0 = insert_cnt;
    clr0 = clear_cnt;
    bridge_mode = 0;
    n = 0;
    while (!(bus.lcd_busy && insert_cnt == ins0 + 1) && n < 50) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 50) begin bad++; $display("FAIL clr_busy_rise: got no busy after insert, expected within 50 cycles"); end
    @(negedge clock);
    bus.clear_req = 1'b1;
    exp_q.delete();
    @(negedge clock);
    bus.clear_req = 1'b0;
    total += 3;
    if (bus.count !== 4'd0) begin bad++; $display("FAIL clr_count: got %0d expected 0", bus.count); end
    if (bus.overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow: got %b expected 0", bus.overflow); end
    if (bus.lcd_clear !== 1'b0) begin bad++; $display("FAIL clr_early: got %b expected 0 while busy", bus.lcd_clear); end
    wait_idle(200, ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL clr_idle_timeout: got busy, expected idle within 200 cycles"); end
    if (clear_cnt - clr0 != 1) begin bad++; $display("FAIL clr_pulses: got %0d expected 1", clear_cnt - clr0); end
    if (insert_cnt - ins0 != 1) begin bad++; $display("FAIL clr_inserts: got %0d expected 1", insert_cnt - ins0); end
  endtask

  task automatic test_full_push_pop;
    bit ok;
    int ins0;
    bridge_mode = 1;
    repeat (2) @(negedge clock);
    for (int i = 1; i <= DEPTH; i++) lap(32'h300 + 32'(i), 1'b1);
    total++;
    if (bus.full !== 1'b1) begin bad++; $display("FAIL fpp_full: got %b expected 1", bus.full); end
    ins0 = insert_cnt;
    bridge_mode = 0;
    @(negedge clock);
    lap(32'h309, 1'b1);
    total += 2;
    if (bus.count !== 4'd8) begin bad++; $display("FAIL fpp_count: got %0d expected 8", bus.count); end
    if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow: got %b expected 0", bus.overflow); end
    wait_idle(600, ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL fpp_idle_timeout: got busy, expected idle within 600 cycles"); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL fpp_drain: got %0d records left, expected 0", exp_q.size()); end
    if (insert_cnt - ins0 != 9) begin bad++; $display("FAIL fpp_inserts: got %0d expected 9", insert_cnt - ins0); end
  endtask

  task automatic test_timeout;
    bit ok;
    bridge_mode = 2;
    @(negedge clock);
    ins_cyc.delete();
    lap(32'h401, 1'b1);
    lap(32'h402, 1'b1);
    wait_idle(200, ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL tmo_idle_timeout: got busy, expected idle within 200 cycles"); end
    if (ins_cyc.size() != 2) begin
      bad++;
      $display("FAIL tmo_inserts: got %0d expected 2", ins_cyc.size());
    end else if (ins_cyc[1] - ins_cyc[0] != ACK_TIMEOUT + 1) begin
      bad++;
      $display("FAIL tmo_spacing: got %0d expected %0d", ins_cyc[1] - ins_cyc[0], ACK_TIMEOUT + 1);
    end
    if (bus.q_busy !== 1'b0) begin bad++; $display("FAIL tmo_q_busy: got %b expected 0", bus.q_busy); end
  endtask

  task automatic test_async_reset;
    bit ok;
    int ins0, clr0, n;
    bridge_mode = 2;
    ins0 = insert_cnt;
    lap(32'h501, 1'b1);
    lap(32'h502, 1'b0);
    n = 0;
    while (insert_cnt == ins0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 20) begin bad++; $display("FAIL ar_insert: got no insert, expected within 20 cycles"); end
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    total += 5;
    if (bus.lcd_insert !== 1'b0) begin bad++; $display("FAIL ar_insert_low: got %b expected 0", bus.lcd_insert); end
    if (bus.lcd_clear  !== 1'b0) begin bad++; $display("FAIL ar_clear_low: got %b expected 0", bus.lcd_clear); end
    if (bus.lcd_record !== 32'h0) begin bad++; $display("FAIL ar_record: got %h expected 0", bus.lcd_record); end
    if (bus.count      !== 4'd0) begin bad++; $display("FAIL ar_count: got %0d expected 0", bus.count); end
    if (bus.q_busy     !== 1'b0) begin bad++; $display("FAIL ar_q_busy: got %b expected 0", bus.q_busy); end
    @(negedge clock);
    reset = 1'b1;
    ins0 = insert_cnt;
    clr0 = clear_cnt;
    repeat (40) @(negedge clock);
    total += 2;
    if (insert_cnt != ins0) begin bad++; $display("FAIL ar_no_insert: got %0d inserts expected 0", insert_cnt - ins0); end
    if (clear_cnt != clr0) begin bad++; $display("FAIL ar_no_clear: got %0d clears expected 0", clear_cnt - clr0); end
    lap(32'h503, 1'b1);
    wait_idle(100, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL ar_idle_timeout: got busy, expected idle within 100 cycles"); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL ar_restart: got %0d records left, expected 0", exp_q.size()); end
  endtask

  initial begin
    bus.lap_req   = 1'b0;
    bus.record_in = '0;
    bus.clear_req = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_clear_inflight();
    test_full_push_pop();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
